stepdir_generator: RTL
======================

Name: stepdir_generator

Overview:
Single-axis step/direction pulse generator. It is the parametrised successor to the fixed-direction step generator on the quad stepper FPGA.
- Adds a direction request with a guaranteed dir-to-step setup time, a configurable pulse width and a minimum-period clamp.
- Adds enable/stop control and a signed position counter.
- One instance per motor axis, driven from the host-register block; outputs go to the driver pins.

Parameters:
PERIOD_BITS, 32, width of the period input (clock cycles between step rising edges)
PULSE_TICKS, 160, step high time in clock cycles (>=1)
DIR_SETUP_TICKS, 40, cycles dir must be stable before a step rising edge (>=1)
POS_BITS, 32, width of the signed position counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
enable  input  1  run request; level-sensitive
period  input  PERIOD_BITS  unsigned step period in cycles; 0 = stop
reverse  input  1  requested direction; 0 = forward (dir=1), 1 = reverse (dir=0)
pos_load  input  1  one-cycle strobe: preset position
pos_value  input  POS_BITS  preset value
step  output  1  step pulse to driver
dir  output  1  direction to driver
position  output  POS_BITS  signed step count
busy  output  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: step=0, dir=1, position=0, busy=0, state=IDLE, all counters 0. Reset mid-pulse drops step on the next edge.
- Effective period: eff = max(period, PULSE_TICKS+1), computed combinationally from the live period input.
- Run condition: run = enable && period!=0.
- States:
  - IDLE: step=0. If run and reverse==!dir, go to PULSE; step is high from the edge after enable is sampled. If run and the direction differs, go to DIRCHG.
  - DIRCHG: dir toggles on entry. Wait exactly DIR_SETUP_TICKS cycles with step=0. Then go to PULSE if run, otherwise IDLE (dir keeps its new value).
  - PULSE: step=1 for exactly PULSE_TICKS cycles, then go to GAP. The pulse is never truncated by enable or period changes; only rst aborts it.
  - GAP: step=0. Cycle counter ticks counts from the rising edge (rising-edge cycle = 0).
    - If !run, go to IDLE immediately.
    - When ticks == eff-1: go to PULSE if the direction matches, otherwise DIRCHG. Rising edges are therefore exactly eff cycles apart when the direction is unchanged.
- Direction change: adds DIR_SETUP_TICKS cycles to that interval. dir never changes while step=1 or within DIR_SETUP_TICKS cycles before a rising edge.
- Period updates: a new period takes effect on the GAP compare in progress. If the new eff <= current ticks, the next step fires on the following cycle.
- Position:
  - Updated on the cycle step rises: +1 if dir=1, -1 if dir=0.
  - Two's-complement; wraps modulo 2^POS_BITS.
  - pos_load in the same cycle as a step rise: position <= pos_value ± 1. pos_load alone: position <= pos_value.
- Widths: ticks is PERIOD_BITS wide. PULSE_TICKS and DIR_SETUP_TICKS counters are sized with $clog2(x+1).

Optional Feature:
Macro POSITION_LIMIT_EN.
- When defined, adds the following ports:
  - limit_min input POS_BITS (signed)
  - limit_max input POS_BITS (signed)
  - at_limit output 1 (reset value 0)
- Compiled in:
  - A step that would move position below limit_min or above limit_max is suppressed. The FSM stays in GAP (or IDLE), step stays 0 and position is unchanged.
  - at_limit is asserted while suppressing and clears on the first allowed step or when run drops.
  - Steps in the opposite direction proceed normally.
- Compiled out: no extra ports, and position wraps freely.

Test Plan:
- Reset, then enable=1, period=1000, reverse=0 → step rises 1 cycle after enable sampled, high 160 cycles; rising edges every 1000 cycles; dir=1; position 1,2,3…
- period=50 (below 161) → rising edges every 161 cycles, step high 160, low 1.
- Running forward, set reverse=1 → at the next due edge dir drops, then 40 cycles later step rises; that interval = period+40; position decrements; dir stable whenever step=1.
- Drop enable mid-pulse at cycle 80 of a pulse → pulse completes all 160 cycles, FSM goes to IDLE, busy=0, no further steps; set period=0 while running → same stop behaviour.
- pos_load=1, pos_value=-5 coincident with a forward step rise → position=-4; position at 0x7FFFFFFF stepping forward → 0x80000000.
- POSITION_LIMIT_EN: limit_max=3, forward from 0 → position stops at 3, at_limit=1, step stays 0; set reverse=1 → steps resume and position goes 2, at_limit=0.

Source files
------------

// File: rtl/stepdir_generator.sv
// Single-axis step/direction pulse generator with direction setup time,
// fixed pulse width, minimum-period clamp and signed position counter.
// Optional feature macro: POSITION_LIMIT_EN (soft position limits).
module stepdir_generator #(
  parameter int unsigned PERIOD_BITS     = 32,
  parameter int unsigned PULSE_TICKS     = 160,
  parameter int unsigned DIR_SETUP_TICKS = 40,
  parameter int unsigned POS_BITS        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic                   reverse,
  input  logic                   pos_load,
  input  logic [POS_BITS-1:0]    pos_value,
`ifdef POSITION_LIMIT_EN
  input  logic [POS_BITS-1:0]    limit_min,
  input  logic [POS_BITS-1:0]    limit_max,
  output logic                   at_limit,
`endif
  output logic                   step,
  output logic                   dir,
  output logic [POS_BITS-1:0]    position,
  output logic                   busy
);

  localparam int unsigned PW = $clog2(PULSE_TICKS + 1);
  localparam int unsigned SW = $clog2(DIR_SETUP_TICKS + 1);
  localparam logic [PERIOD_BITS-1:0] MIN_EFF = PERIOD_BITS'(PULSE_TICKS + 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_TICKS - 1);
  localparam logic [SW-1:0] SETUP_LOAD = SW'(DIR_SETUP_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRCHG = 2'd1,
    PULSE  = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   step_q, step_d;
  logic                   dir_q, dir_d;
  logic                   busy_q, busy_d;
  logic [POS_BITS-1:0]    position_q, position_d;
  logic [PERIOD_BITS-1:0] ticks_q, ticks_d;
  logic [PW-1:0]          pulse_cnt_q, pulse_cnt_d;
  logic [SW-1:0]          setup_cnt_q, setup_cnt_d;

  logic [PERIOD_BITS-1:0] eff_c;
  logic                   run_c;
  logic                   dir_match_c;
  logic                   due_c;
  logic                   limit_hit_c;
  logic                   fire_c;
  logic [POS_BITS-1:0]    pos_base_c;

  // Effective period, run request and GAP compare from the live inputs
  always_comb begin
    eff_c       = (period >= MIN_EFF) ? period : MIN_EFF;
    run_c       = enable && (period != '0);
    dir_match_c = (dir_q == ~reverse);
    due_c       = (ticks_q >= (eff_c - PERIOD_BITS'(1)));
  end

`ifdef POSITION_LIMIT_EN
  // A step in the current direction would leave the [limit_min, limit_max] window
  always_comb begin
    if (dir_q) limit_hit_c = ($signed(position_q) >= $signed(limit_max));
    else       limit_hit_c = ($signed(position_q) <= $signed(limit_min));
  end
`else
  // Limits compiled out: every step is allowed
  always_comb begin
    limit_hit_c = 1'b0;
  end
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    step_d      = 1'b0;
    dir_d       = dir_q;
    ticks_d     = ticks_q;
    pulse_cnt_d = pulse_cnt_q;
    setup_cnt_d = setup_cnt_q;
    fire_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run_c) begin
          if (!dir_match_c) begin
            state_d     = DIRCHG;
            dir_d       = ~dir_q;
            setup_cnt_d = SETUP_LOAD;
          end else if (!limit_hit_c) begin
            fire_c = 1'b1;
          end
        end
      end
      DIRCHG: begin
        if (setup_cnt_q == '0) begin
          if (!run_c) begin
            state_d = IDLE;
          end else if (!limit_hit_c) begin
            fire_c = 1'b1;
          end else begin
            // Blocked right after a turn: park in GAP with the compare already due
            state_d = GAP;
            ticks_d = eff_c - PERIOD_BITS'(1);
          end
        end else begin
          setup_cnt_d = setup_cnt_q - SW'(1);
        end
      end
      PULSE: begin
        ticks_d = ticks_q + PERIOD_BITS'(1);
        if (pulse_cnt_q == '0) begin
          state_d = GAP;
        end else begin
          step_d      = 1'b1;
          pulse_cnt_d = pulse_cnt_q - PW'(1);
        end
      end
      GAP: begin
        if (!run_c) begin
          state_d = IDLE;
        end else if (due_c) begin
          if (!dir_match_c) begin
            state_d     = DIRCHG;
            dir_d       = ~dir_q;
            setup_cnt_d = SETUP_LOAD;
          end else if (!limit_hit_c) begin
            fire_c = 1'b1;
          end
          // Suppressed step: hold ticks so the compare stays due
        end else begin
          ticks_d = ticks_q + PERIOD_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (fire_c) begin
      state_d     = PULSE;
      step_d      = 1'b1;
      ticks_d     = '0;
      pulse_cnt_d = PULSE_LOAD;
    end

    pos_base_c = pos_load ? pos_value : position_q;
    if (fire_c) position_d = pos_base_c + (dir_q ? POS_BITS'(1) : {POS_BITS{1'b1}});
    else        position_d = pos_base_c;

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= 1'b0;
      dir_q       <= 1'b1;
      busy_q      <= 1'b0;
      position_q  <= '0;
      ticks_q     <= '0;
      pulse_cnt_q <= '0;
      setup_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      position_q  <= position_d;
      ticks_q     <= ticks_d;
      pulse_cnt_q <= pulse_cnt_d;
      setup_cnt_q <= setup_cnt_d;
    end
  end

`ifdef POSITION_LIMIT_EN
  logic at_limit_q, at_limit_d;
  logic block_c;

  // Flag set while a due step is being suppressed; cleared by a step or by stopping
  always_comb begin
    block_c = run_c && limit_hit_c &&
              (((state_q == IDLE) && dir_match_c) ||
               ((state_q == GAP) && due_c && dir_match_c) ||
               ((state_q == DIRCHG) && (setup_cnt_q == '0)));
    at_limit_d = at_limit_q;
    if (!run_c || fire_c) at_limit_d = 1'b0;
    else if (block_c)     at_limit_d = 1'b1;
  end

  // Limit flag register
  always_ff @(posedge clk) begin
    if (rst) at_limit_q <= 1'b0;
    else     at_limit_q <= at_limit_d;
  end

  assign at_limit = at_limit_q;
`endif

  assign step     = step_q;
  assign dir      = dir_q;
  assign busy     = busy_q;
  assign position = position_q;

endmodule
